i2s_fir_mac_nch: RTL and testbench

//  N-channel, time-multiplexed FIR filter for the I2S audio path. It sits between the I2S receiver
//  and the I2S transmitter/FFT. It replaces per-channel parallel multiplier trees with one shared

---
 rtl/i2s_fir_mac_nch_if.sv | 32 +++
 rtl/i2s_fir_mac_nch.sv | 152 +++++++++++++++
 tb/tb_i2s_fir_mac_nch.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_fir_mac_nch_if.sv
// rtl/i2s_fir_mac_nch_if.sv - sample, coefficient and output signal bundle for i2s_fir_mac_nch
interface i2s_fir_mac_nch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 31,
  parameter int NUM_CH     = 2
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(TAPS);

  logic                  in_vld;
  logic                  in_rdy;
  logic [CW-1:0]         in_ch;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  coef_we;
  logic [AW-1:0]         coef_addr;
  logic [COEF_WIDTH-1:0] coef_wdata;
  logic                  out_vld;
  logic [CW-1:0]         out_ch;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  sat_flag;

  modport master (
    output in_vld, in_ch, in_data, coef_we, coef_addr, coef_wdata,
    input  in_rdy, out_vld, out_ch, out_data, sat_flag
  );

  modport slave (
    input  in_vld, in_ch, in_data, coef_we, coef_addr, coef_wdata,
    output in_rdy, out_vld, out_ch, out_data, sat_flag
  );
endinterface

// File: rtl/i2s_fir_mac_nch.sv
// rtl/i2s_fir_mac_nch.sv - N-channel time-multiplexed FIR with one shared MAC, rounding and saturation
module i2s_fir_mac_nch #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 31,
  parameter int NUM_CH     = 2,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_SHIFT  = 15,
  parameter int GAIN_SHIFT = 1
) (
  input logic              sck,
  input logic              rst_n,
  i2s_fir_mac_nch_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_LIM = (AW + 1)'(TAPS);
  localparam logic [CW:0]   NCH_LIM  = (CW + 1)'(NUM_CH);

  // Half an output LSB, so the arithmetic shift rounds half up; no rounding when nothing is shifted out.
  localparam logic signed [ACC_WIDTH-1:0] RND =
    (OUT_SHIFT > 0) ? (ACC_WIDTH'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] hist [NUM_CH][TAPS];
  logic signed [COEF_WIDTH-1:0] coef [TAPS];
  logic [AW-1:0]                wp   [NUM_CH];
  logic [AW-1:0]                rp;
  logic [AW-1:0]                k;
  logic [CW-1:0]                ch_r;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic                  in_rdy_r;
  logic                  out_vld_r;
  logic [CW-1:0]         out_ch_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  sat_r;

  logic                         accept;
  logic                         coef_wr_ok;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  rnd_sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [ACC_WIDTH-1:0]  gained;
  logic                         sat_hi;
  logic                         sat_lo;
  logic [DATA_WIDTH-1:0]        sat_val;

  assign bus.in_rdy   = in_rdy_r;
  assign bus.out_vld  = out_vld_r;
  assign bus.out_ch   = out_ch_r;
  assign bus.out_data = out_data_r;
  assign bus.sat_flag = sat_r;

  // Sample acceptance and coefficient-write qualification; both only matter in IDLE.
  always_comb begin
    accept     = (state == S_IDLE) && bus.in_vld && ({1'b0, bus.in_ch} < NCH_LIM);
    coef_wr_ok = bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_LIM);
  end

  // Shared multiplier for the current tap, plus the round / gain / clip path fed from the accumulator.
  always_comb begin
    prod     = hist[ch_r][rp] * coef[k];
    prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
    rnd_sum  = acc + RND;
    shifted  = rnd_sum >>> OUT_SHIFT;
    gained   = shifted <<< GAIN_SHIFT;
    sat_hi   = gained > MAXV;
    sat_lo   = gained < MINV;
    if (sat_hi) begin
      sat_val = MAXV[DATA_WIDTH-1:0];
    end else if (sat_lo) begin
      sat_val = MINV[DATA_WIDTH-1:0];
    end else begin
      sat_val = gained[DATA_WIDTH-1:0];
    end
  end

  // Control FSM with its datapath: accept into history, walk the taps, then round and publish.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_rdy_r   <= 1'b1;
      out_vld_r  <= 1'b0;
      out_ch_r   <= '0;
      out_data_r <= '0;
      sat_r      <= 1'b0;
      acc        <= '0;
      k          <= '0;
      rp         <= '0;
      ch_r       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wp[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          hist[c][t] <= '0;
        end
      end
      for (int t = 0; t < TAPS; t++) begin
        coef[t] <= '0;
      end
    end else begin
      out_vld_r <= 1'b0;
      sat_r     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (coef_wr_ok) begin
            coef[bus.coef_addr] <= $signed(bus.coef_wdata);
          end
          if (accept) begin
            hist[bus.in_ch][wp[bus.in_ch]] <= $signed(bus.in_data);
            ch_r     <= bus.in_ch;
            rp       <= wp[bus.in_ch];
            k        <= '0;
            acc      <= '0;
            in_rdy_r <= 1'b0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          rp  <= (rp == LAST_IDX) ? '0 : rp + 1'b1;
          k   <= k + 1'b1;
          if (k == LAST_IDX) begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          out_data_r <= sat_val;
          out_ch_r   <= ch_r;
          sat_r      <= sat_hi | sat_lo;
          out_vld_r  <= 1'b1;
          wp[ch_r]   <= (wp[ch_r] == '0) ? LAST_IDX : wp[ch_r] - 1'b1;
          in_rdy_r   <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_fir_mac_nch.sv
// tb/tb_i2s_fir_mac_nch.sv - directed table and sequence bench for i2s_fir_mac_nch
module tb_i2s_fir_mac_nch;
  localparam int TAPS   = 31;
  localparam int NUM_CH = 3;
  localparam int LAT    = TAPS + 2;

  logic sck;
  logic rst_n;
  int   errors;
  int   checks;

  i2s_fir_mac_nch_if #(.DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS), .NUM_CH(NUM_CH)) bus ();

  i2s_fir_mac_nch #(
    .DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS), .NUM_CH(NUM_CH),
    .ACC_WIDTH(40), .OUT_SHIFT(15), .GAIN_SHIFT(1)
  ) dut (
    .sck  (sck),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, expected finish before 5ms");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int ch;
    int data;
    int exp_data;
    bit exp_sat;
  } vec_t;

  int m_coef [TAPS];
  int m_hist [NUM_CH][TAPS];
  int m_wp   [NUM_CH];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_wp[c] = 0;
      for (int t = 0; t < TAPS; t++) m_hist[c][t] = 0;
    end
    for (int t = 0; t < TAPS; t++) m_coef[t] = 0;
  endtask

  // Reference: newest sample at wp, older samples at increasing index, half-up rounding, x2 gain, clip.
  task automatic m_push(input int ch, input int d, output int e, output bit s);
    longint a;
    longint r;
    a = 0;
    m_hist[ch][m_wp[ch]] = d;
    for (int t = 0; t < TAPS; t++)
      a += longint'(m_hist[ch][(m_wp[ch] + t) % TAPS]) * longint'(m_coef[t]);
    r = (a + 64'sd16384) >>> 15;
    r = r * 2;
    if (r > 32767) begin
      e = 32767; s = 1'b1;
    end else if (r < -32768) begin
      e = -32768; s = 1'b1;
    end else begin
      e = int'(r); s = 1'b0;
    end
    m_wp[ch] = (m_wp[ch] == 0) ? TAPS - 1 : m_wp[ch] - 1;
  endtask

  task automatic do_reset();
    @(negedge sck);
    rst_n          = 1'b0;
    bus.in_vld     = 1'b0;
    bus.in_ch      = '0;
    bus.in_data    = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    repeat (2) @(negedge sck);
    rst_n = 1'b1;
    m_clear();
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge sck);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 5'(addr);
    bus.coef_wdata = 16'(val);
    @(negedge sck);
    bus.coef_we = 1'b0;
    if (addr < TAPS) m_coef[addr] = val;
  endtask

  task automatic send(input int ch, input int d, input int exp_d, input bit exp_s, input string nm);
    int n;
    bit got;
    @(negedge sck);
    n = 0;
    while (!bus.in_rdy && n < 100) begin
      @(negedge sck);
      n++;
    end
    if (!bus.in_rdy) chk({nm, "_rdy_timeout"}, 0, 1);
    bus.in_vld  = 1'b1;
    bus.in_ch   = 2'(ch);
    bus.in_data = 16'(d);
    @(negedge sck);
    bus.in_vld = 1'b0;
    n   = 1;
    got = 1'b0;
    while (n <= LAT + 8 && !got) begin
      if (bus.out_vld) got = 1'b1;
      else begin
        @(negedge sck);
        n++;
      end
    end
    chk({nm, "_out_vld_seen"}, longint'(got), 1);
    chk({nm, "_latency"}, n, LAT);
    chk({nm, "_data"}, longint'($signed(bus.out_data)), exp_d);
    chk({nm, "_ch"}, longint'(bus.out_ch), ch);
    chk({nm, "_sat"}, longint'(bus.sat_flag), longint'(exp_s));
  endtask

  task automatic push_chk(input int ch, input int d, input string nm);
    int e;
    bit s;
    m_push(ch, d, e, s);
    send(ch, d, e, s, nm);
  endtask

  task automatic impulse_run(input string nm);
    int e;
    bit s;
    for (int k = 0; k < TAPS; k++) write_coef(k, 2 * (k + 1));
    for (int j = 0; j < TAPS; j++) begin
      m_push(0, (j == 0) ? 16384 : 0, e, s);
      send(0, (j == 0) ? 16384 : 0, 2 * (j + 1), 1'b0, nm);
    end
  endtask

  vec_t vecs [8];
  int   e_tmp;
  bit   s_tmp;
  int   acc_n, out_n, rdy_low, n;
  bit   got, bad_vld, bad_rdy;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.in_vld = 1'b0; bus.in_ch = '0; bus.in_data = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;

    // Channel isolation / rounding / clip boundary table, coef[0]=0.5 and x2 gain -> unity.
    vecs[0] = '{0,   1000,   1000, 1'b0};
    vecs[1] = '{1,  -2000,  -2000, 1'b0};
    vecs[2] = '{0,      1,      2, 1'b0};
    vecs[3] = '{1,     -1,      0, 1'b0};
    vecs[4] = '{0, -32768, -32768, 1'b0};
    vecs[5] = '{1,  32767,  32767, 1'b1};
    vecs[6] = '{2,    500,    500, 1'b0};
    vecs[7] = '{0,      3,      4, 1'b0};

    do_reset();
    chk("rst_in_rdy", longint'(bus.in_rdy), 1);
    chk("rst_out_vld", longint'(bus.out_vld), 0);
    chk("rst_out_ch", longint'(bus.out_ch), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_sat", longint'(bus.sat_flag), 0);

    impulse_run("impulse");
    repeat (5) @(negedge sck);
    chk("hold_out_data", longint'($signed(bus.out_data)), 62);

    do_reset();
    write_coef(0, 16384);
    for (int i = 0; i < 8; i++) begin
      m_push(vecs[i].ch, vecs[i].data, e_tmp, s_tmp);
      send(vecs[i].ch, vecs[i].data, vecs[i].exp_data, vecs[i].exp_sat, $sformatf("tbl%0d", i));
    end

    // Illegal channel index: dropped, no output, block stays ready.
    @(negedge sck);
    bus.in_vld = 1'b1; bus.in_ch = 2'd3; bus.in_data = 16'd1234;
    @(negedge sck);
    bus.in_vld = 1'b0;
    bad_vld = 1'b0; bad_rdy = 1'b0;
    for (int c = 0; c < LAT + 8; c++) begin
      if (bus.out_vld) bad_vld = 1'b1;
      if (!bus.in_rdy) bad_rdy = 1'b1;
      @(negedge sck);
    end
    chk("illegal_ch_no_out", longint'(bad_vld), 0);
    chk("illegal_ch_rdy", longint'(bad_rdy), 0);
    push_chk(0, 777, "after_illegal");

    // Continuous in_vld: one accept per TAPS+2 cycles, mid-MAC coef write ignored.
    acc_n = 0; out_n = 0; rdy_low = 0;
    @(negedge sck);
    bus.in_vld = 1'b1; bus.in_ch = 2'd1; bus.in_data = 16'd100;
    for (int c = 0; c < 3 * LAT + 1; c++) begin
      if (c == 5) begin bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_wdata = '0; end
      if (c == 6) bus.coef_we = 1'b0;
      if (bus.in_rdy) acc_n++; else rdy_low++;
      if (bus.out_vld) begin
        out_n++;
        chk("hs_data", longint'($signed(bus.out_data)), 100);
        chk("hs_ch", longint'(bus.out_ch), 1);
      end
      @(negedge sck);
    end
    bus.in_vld = 1'b0;
    for (int i = 0; i < 4; i++) m_push(1, 100, e_tmp, s_tmp);
    chk("hs_accepts", acc_n, 4);
    chk("hs_outputs", out_n, 3);
    chk("hs_rdy_low", rdy_low, 3 * (LAT - 1));
    got = 1'b0; n = 0;
    while (n < LAT + 8 && !got) begin
      if (bus.out_vld) got = 1'b1;
      else begin @(negedge sck); n++; end
    end
    chk("hs_last_seen", longint'(got), 1);
    chk("hs_last_data", longint'($signed(bus.out_data)), 100);

    // Saturation both ways with full-scale coefficients.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < TAPS - 1; i++) push_chk(0, 32767, "satp");
    m_push(0, 32767, e_tmp, s_tmp);
    send(0, 32767, 32767, 1'b1, "sat_pos_full");
    for (int i = 0; i < TAPS - 1; i++) push_chk(0, -32768, "satn");
    m_push(0, -32768, e_tmp, s_tmp);
    send(0, -32768, -32768, 1'b1, "sat_neg_full");

    // Pointer wrap over more than 2*TAPS samples, with interleaved traffic on another channel.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, ((k * 1031) % 4001) - 2000);
    write_coef(31, 12345);
    for (int i = 0; i < 2 * TAPS + 8; i++) begin
      push_chk(2, ((i * 7919) % 20001) - 10000, "wrap_ch2");
      if (i % 10 == 0) push_chk(0, i * 50 - 1500, "wrap_ch0");
    end

    // Reset in the middle of MAC: no output, ready, cleared state.
    write_coef(0, 16384);
    @(negedge sck);
    bus.in_vld = 1'b1; bus.in_ch = 2'd0; bus.in_data = 16'd9000;
    @(negedge sck);
    bus.in_vld = 1'b0;
    repeat (9) @(negedge sck);
    rst_n = 1'b0;
    @(negedge sck);
    rst_n = 1'b1;
    m_clear();
    bad_vld = 1'b0; bad_rdy = 1'b0;
    for (int c = 0; c < LAT + 8; c++) begin
      if (bus.out_vld) bad_vld = 1'b1;
      if (!bus.in_rdy) bad_rdy = 1'b1;
      @(negedge sck);
    end
    chk("midmac_no_out", longint'(bad_vld), 0);
    chk("midmac_rdy", longint'(bad_rdy), 0);
    chk("midmac_out_data", longint'(bus.out_data), 0);
    impulse_run("impulse2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
